// File: rtl/alu_seq_muldiv_if.sv
// Issue/result bundle between the EX-stage sequencer and the mul/div ALU.
// The master drives operands and the start/abort controls; the slave returns results and flags.
interface alu_seq_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             start;
    logic             abort;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;
    logic             carry;
    logic             div_by_zero;

    modport master (
        output start, abort, op, a, b, shamt,
        input  busy, valid, result_lo, result_hi, zero, overflow, carry, div_by_zero
    );

    modport slave (
        input  start, abort, op, a, b, shamt,
        output busy, valid, result_lo, result_hi, zero, overflow, carry, div_by_zero
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered MIPS EX-stage ALU: one-cycle ops plus iterative shift-add multiply and
// restoring divide on magnitudes, with sign correction applied in a final FIX cycle.
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_muldiv_if.slave  bus
);
    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MULT = 4'h2, OP_DIV   = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4, OP_SRL  = 4'h5, OP_ADDU = 4'h6, OP_SUBU  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR   = 4'hB;
    localparam logic [3:0] OP_MULTU = 4'hC, OP_SLT = 4'hD, OP_SLTU = 4'hE, OP_DIVU  = 4'hF;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_reg, state_next;
    logic [SHW-1:0]     cnt_reg, cnt_next;
    logic               is_div_reg, is_div_next;
    logic               is_signed_reg, is_signed_next;
    logic               neg_lo_reg, neg_lo_next;
    logic               neg_hi_reg, neg_hi_next;
    logic               div_ovf_reg, div_ovf_next;
    logic [WIDTH-1:0]   dvsr_reg, dvsr_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               busy_reg, busy_next;
    logic               valid_reg, valid_next;
    logic [WIDTH-1:0]   res_lo_reg, res_lo_next;
    logic [WIDTH-1:0]   res_hi_reg, res_hi_next;
    logic               zero_reg, zero_next;
    logic               ovf_reg, ovf_next;
    logic               carry_reg, carry_next;
    logic               dbz_reg, dbz_next;

    // Operand decode and magnitudes for the iterative engine
    logic               is_mul_op, is_div_op, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    assign is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_neg     = signed_op && bus.a[WIDTH-1];
    assign b_neg     = signed_op && bus.b[WIDTH-1];
    assign a_abs     = a_neg ? -bus.a : bus.a;
    assign b_abs     = b_neg ? -bus.b : bus.b;

    logic [WIDTH:0]     add_full, sub_full;
    assign add_full = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_full = {1'b0, bus.a} - {1'b0, bus.b};

    // One iteration step: hi_reg is the accumulator/remainder, lo_reg the multiplier/quotient
    logic [WIDTH:0]     mul_sum, rem_shift;
    logic               rem_take;
    logic [WIDTH-1:0]   rem_diff;
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, dvsr_reg} : '0);
    assign rem_shift = {hi_reg, lo_reg[WIDTH-1]};
    assign rem_take  = rem_shift >= {1'b0, dvsr_reg};
    assign rem_diff  = rem_shift[WIDTH-1:0] - dvsr_reg;

    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic               mul_ovf;
    assign prod_raw = {hi_reg, lo_reg};
    assign prod_fix = neg_lo_reg ? -prod_raw : prod_raw;
    assign q_fix    = neg_lo_reg ? -lo_reg : lo_reg;
    assign r_fix    = neg_hi_reg ? -hi_reg : hi_reg;
    assign mul_ovf  = is_signed_reg ? (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}})
                                    : (prod_fix[2*WIDTH-1:WIDTH] != '0);

    logic [WIDTH-1:0]   sc_lo, sc_hi;
    logic               sc_ovf, sc_carry, sc_dbz;
    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_ovf   = 1'b0;
        sc_carry = 1'b0;
        sc_dbz   = 1'b0;
        case (bus.op)
            OP_ADD:  begin
                sc_lo  = add_full[WIDTH-1:0];
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB:  begin
                sc_lo  = sub_full[WIDTH-1:0];
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ADDU: begin sc_lo = add_full[WIDTH-1:0]; sc_carry = add_full[WIDTH]; end
            OP_SUBU: begin sc_lo = sub_full[WIDTH-1:0]; sc_carry = sub_full[WIDTH]; end
            OP_SLL:  sc_lo = bus.a << bus.shamt;
            OP_SRL:  sc_lo = bus.a >> bus.shamt;
            OP_AND:  sc_lo = bus.a & bus.b;
            OP_OR:   sc_lo = bus.a | bus.b;
            OP_XOR:  sc_lo = bus.a ^ bus.b;
            OP_NOR:  sc_lo = ~(bus.a | bus.b);
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            // Only reached with b == 0: divide completes immediately with a saturated quotient
            OP_DIV, OP_DIVU: begin sc_lo = '1; sc_hi = bus.a; sc_dbz = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        is_div_next    = is_div_reg;
        is_signed_next = is_signed_reg;
        neg_lo_next    = neg_lo_reg;
        neg_hi_next    = neg_hi_reg;
        div_ovf_next   = div_ovf_reg;
        dvsr_next      = dvsr_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        busy_next      = busy_reg;
        valid_next     = 1'b0;
        res_lo_next    = res_lo_reg;
        res_hi_next    = res_hi_reg;
        zero_next      = zero_reg;
        ovf_next       = ovf_reg;
        carry_next     = carry_reg;
        dbz_next       = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (is_mul_op || (is_div_op && bus.b != '0)) begin
                        state_next     = RUN;
                        busy_next      = 1'b1;
                        cnt_next       = '0;
                        is_div_next    = is_div_op;
                        is_signed_next = signed_op;
                        neg_lo_next    = a_neg ^ b_neg;
                        neg_hi_next    = a_neg;
                        div_ovf_next   = (bus.op == OP_DIV) && (bus.b == '1) &&
                                         (bus.a == {1'b1, {(WIDTH-1){1'b0}}});
                        hi_next        = '0;
                        lo_next        = is_mul_op ? b_abs : a_abs;
                        dvsr_next      = is_mul_op ? a_abs : b_abs;
                    end else begin
                        valid_next  = 1'b1;
                        res_lo_next = sc_lo;
                        res_hi_next = sc_hi;
                        zero_next   = (sc_lo == '0);
                        ovf_next    = sc_ovf;
                        carry_next  = sc_carry;
                        dbz_next    = sc_dbz;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    if (is_div_reg) begin
                        hi_next = rem_take ? rem_diff : rem_shift[WIDTH-1:0];
                        lo_next = {lo_reg[WIDTH-2:0], rem_take};
                    end else begin
                        {hi_next, lo_next} = {mul_sum, lo_reg[WIDTH-1:1]};
                    end
                    if (cnt_reg == SHW'(WIDTH-1)) state_next = FIX;
                    else                          cnt_next   = cnt_reg + 1'b1;
                end
            end
            FIX: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                if (!bus.abort) begin
                    valid_next = 1'b1;
                    carry_next = 1'b0;
                    dbz_next   = 1'b0;
                    if (is_div_reg) begin
                        res_lo_next = q_fix;
                        res_hi_next = r_fix;
                        zero_next   = (q_fix == '0);
                        ovf_next    = div_ovf_reg;
                    end else begin
                        res_lo_next = prod_fix[WIDTH-1:0];
                        res_hi_next = prod_fix[2*WIDTH-1:WIDTH];
                        zero_next   = (prod_fix[WIDTH-1:0] == '0);
                        ovf_next    = mul_ovf;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            is_div_reg    <= 1'b0;
            is_signed_reg <= 1'b0;
            neg_lo_reg    <= 1'b0;
            neg_hi_reg    <= 1'b0;
            div_ovf_reg   <= 1'b0;
            dvsr_reg      <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            res_lo_reg    <= '0;
            res_hi_reg    <= '0;
            zero_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            is_div_reg    <= is_div_next;
            is_signed_reg <= is_signed_next;
            neg_lo_reg    <= neg_lo_next;
            neg_hi_reg    <= neg_hi_next;
            div_ovf_reg   <= div_ovf_next;
            dvsr_reg      <= dvsr_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            busy_reg      <= busy_next;
            valid_reg     <= valid_next;
            res_lo_reg    <= res_lo_next;
            res_hi_reg    <= res_hi_next;
            zero_reg      <= zero_next;
            ovf_reg       <= ovf_next;
            carry_reg     <= carry_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.valid       = valid_reg;
    assign bus.result_lo   = res_lo_reg;
    assign bus.result_hi   = res_hi_reg;
    assign bus.zero        = zero_reg;
    assign bus.overflow    = ovf_reg;
    assign bus.carry       = carry_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule
